// File: rtl/gray2bin_pipe.sv
// gray2bin_pipe: streaming Gray-to-binary decoder built as a registered log-step prefix-XOR pipeline with valid/ready.
// Define GRAY_STEP_CHECK_EN to flag consecutive accepted words that do not differ in exactly one bit.
module gray2bin_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step_err
);
    localparam int NSTEPS = $clog2(WIDTH);
    logic [WIDTH-1:0] data [1:NSTEPS];
    logic [WIDTH-1:0] src [1:NSTEPS];
    logic [NSTEPS:1]  v, src_v, rdy;
    logic             full;
    // A stage may load while any stage at or after it is empty, or the consumer is taking a word.
    always_comb begin
        full = 1'b1;
        rdy = '0;
        for (int k = NSTEPS; k >= 1; k--) begin
            full = full && v[k];
            rdy[k] = out_ready || !full;
        end
    end
    always_comb begin
        src[1] = gray_in;
        src_v = '0;
        src_v[1] = in_valid;
        for (int k = 2; k <= NSTEPS; k++) begin
            src[k] = data[k-1];
            src_v[k] = v[k-1];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 1; k <= NSTEPS; k++) data[k] <= '0;
        end else begin
            for (int k = 1; k <= NSTEPS; k++) begin
                if (rdy[k]) begin
                    v[k] <= src_v[k];
                    data[k] <= src[k] ^ (src[k] >> (1 << (k - 1)));
                end
            end
        end
    end
    assign in_ready  = rdy[1];
    assign bin_out   = data[NSTEPS];
    assign out_valid = v[NSTEPS];
`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] last_gray;
    logic             have_last, err;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gray <= '0;
            have_last <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= in_valid && in_ready && have_last && ($countones(gray_in ^ last_gray) != 1);
            if (in_valid && in_ready) begin
                last_gray <= gray_in;
                have_last <= 1'b1;
            end
        end
    end
    assign step_err = err;
`else
    assign step_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray2bin_pipe.sv
// tb_gray2bin_pipe: directed and random checks of gray2bin_pipe (WIDTH=32) against a scoreboard of reference decodes.
module tb_gray2bin_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gray_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] bin_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        step_err;

    int total = 0;
    int bad = 0;
    int n_emit = 0;
    logic [31:0] q[$];
    logic        have_last = 1'b0;
    logic [31:0] last_gray = '0;

    gray2bin_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .in_valid(in_valid), .in_ready(in_ready),
        .bin_out(bin_out), .out_valid(out_valid), .out_ready(out_ready), .step_err(step_err)
    );

    always #5 clk = ~clk;

    // Spec rule: binary bit i is the XOR of all Gray bits from i upward.
    function automatic logic [31:0] ref_dec(input logic [31:0] g);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [31:0] g, input logic ordy, output logic acc, output logic emit);
        logic exp_err;
        in_valid = iv;
        gray_in = g;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (emit) begin
            n_emit++;
            chk("emit_has_pending_word", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) chk("bin_out_order", 64'(bin_out), 64'(q.pop_front()));
        end
        exp_err = 1'b0;
`ifdef GRAY_STEP_CHECK_EN
        exp_err = acc && have_last && ($countones(g ^ last_gray) != 1);
`endif
        if (acc) begin
            q.push_back(ref_dec(g));
            have_last = 1'b1;
            last_gray = g;
        end
        @(posedge clk);
        #1;
        chk("step_err", 64'(step_err), 64'(exp_err));
        chk("in_flight_le_5", 64'(q.size() <= 5), 64'd1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        have_last = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bin_out", 64'(bin_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_step_err", 64'(step_err), 64'd0);
    endtask

    task automatic drain(input int n);
        logic a, e;
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, a, e);
    endtask

    initial begin
        logic a, e;
        logic [31:0] t1_in [4] = '{32'h0000000C, 32'h80000000, 32'h00000003, 32'h00000000};
        logic [31:0] t1_exp [4] = '{32'h00000008, 32'hFFFFFFFF, 32'h00000002, 32'h00000000};
        logic [31:0] w [8];
        logic [31:0] held;
        int base, j, cnt, pulses;
        @(posedge clk);
        reset_dut();

        // T1: single words, latency and known decodes
        for (int n = 0; n < 4; n++) begin
            cyc(1'b1, t1_in[n], 1'b1, a, e);
            chk("t1_accept", 64'(a), 64'd1);
            for (int c = 0; c < 3; c++) cyc(1'b0, 32'h0, 1'b1, a, e);
            chk("t1_not_early", 64'(out_valid), 64'd0);
            cyc(1'b0, 32'h0, 1'b1, a, e);
            chk("t1_out_valid", 64'(out_valid), 64'd1);
            chk("t1_bin_out", 64'(bin_out), 64'(t1_exp[n]));
        end
        drain(2);

        // T2: full-rate stream of i^(i>>1)
        base = n_emit;
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 32'(i) ^ (32'(i) >> 1), 1'b1, a, e);
            if (!a) cnt++;
        end
        chk("t2_in_ready_drops", 64'(cnt), 64'd0);
        chk("t2_emits_during_stream", 64'(n_emit - base), 64'd1019);
        drain(6);
        chk("t2_emits_total", 64'(n_emit - base), 64'd1024);

        // T3: stall, compaction, hold, then release
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        base = n_emit;
        j = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, w[j], 1'b0, a, e);
            if (a) j++;
        end
        chk("t3_accepted", 64'(j), 64'd5);
        chk("t3_in_ready_low", 64'(in_ready), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        held = bin_out;
        chk("t3_head_word", 64'(held), 64'(ref_dec(w[0])));
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, w[j], 1'b0, a, e);
            chk("t3_no_accept_when_full", 64'(a), 64'd0);
            chk("t3_bin_out_held", 64'(bin_out), 64'(held));
        end
        for (int c = 0; c < 50 && j < 8; c++) begin
            cyc(1'b1, w[j], 1'b1, a, e);
            if (a) j++;
        end
        chk("t3_all_accepted", 64'(j), 64'd8);
        drain(8);
        chk("t3_emitted", 64'(n_emit - base), 64'd8);

        // T4: random valid/ready, random data
        cnt = 0;
        for (int c = 0; c < 60000 && cnt < 10000; c++) begin
            cyc(1'($urandom % 2), $urandom, 1'($urandom % 2), a, e);
            if (a) cnt++;
        end
        chk("t4_accepted", 64'(cnt), 64'd10000);
        drain(10);
        chk("t4_drained", 64'(q.size()), 64'd0);

        // T5: reset with words in flight discards them
        for (int c = 0; c < 3; c++) cyc(1'b1, $urandom, 1'b0, a, e);
        chk("t5_in_flight", 64'(q.size()), 64'd3);
        reset_dut();
        base = n_emit;
        drain(8);
        chk("t5_no_stale_words", 64'(n_emit - base), 64'd0);

        // T6: Gray step checking
        pulses = 0;
        cyc(1'b1, 32'h0, 1'b1, a, e); pulses += int'(step_err);
        cyc(1'b1, 32'h1, 1'b1, a, e); pulses += int'(step_err);
        cyc(1'b1, 32'h3, 1'b1, a, e); pulses += int'(step_err);
        cyc(1'b1, 32'h0, 1'b1, a, e); pulses += int'(step_err);
`ifdef GRAY_STEP_CHECK_EN
        chk("t6_pulse_after_4th", 64'(step_err), 64'd1);
`else
        chk("t6_pulse_after_4th", 64'(step_err), 64'd0);
`endif
        cyc(1'b0, 32'h0, 1'b1, a, e); pulses += int'(step_err);
        cyc(1'b0, 32'h0, 1'b1, a, e); pulses += int'(step_err);
`ifdef GRAY_STEP_CHECK_EN
        chk("t6_pulse_count", 64'(pulses), 64'd1);
`else
        chk("t6_pulse_count", 64'(pulses), 64'd0);
`endif
        drain(6);
        reset_dut();
        cyc(1'b1, 32'h5, 1'b1, a, e);
        chk("t6_first_word_not_flagged", 64'(step_err), 64'd0);
        drain(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
